// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
//   Bundle of the request/data/grant signals between four requesters and the
//   round-robin arbiter that owns the select of a shared 4:1 data mux.
//
//   req       requester -> arbiter  4     one request bit per requester
//   data_in   requester -> arbiter  4*DW  lane i = data_in[i*DW +: DW]
//   grant     arbiter -> requester  4     one-hot owner, zero when idle
//   sel       arbiter -> requester  2     encoded owner (mux select)
//   data_out  arbiter -> requester  DW    selected lane while valid_out, else 0
//   valid_out arbiter -> requester  1     owner is granted and still requesting
//   busy      arbiter -> requester  1     arbiter is in its GRANT state
//
//   master: the requester side (drives req/data_in)
//   slave : the arbiter side (drives grant/sel/data_out/valid_out/busy)
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      req;
    logic [4*DW-1:0] data_in;
    logic [3:0]      grant;
    logic [1:0]      sel;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic            busy;

    modport master (
        output req, data_in,
        input  grant, sel, data_out, valid_out, busy
    );

    modport slave (
        input  req, data_in,
        output grant, sel, data_out, valid_out, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 data mux. One requester
//   owns the mux at a time; ownership is held until the owner drops its request
//   or MAX_HOLD consecutive cycles have elapsed. Handoff to the next requester
//   happens on the same edge as the release, so there is no idle bubble.
//
//   Parameters
//     DW        width of each data lane and of data_out
//     MAX_HOLD  maximum consecutive cycles a single grant is held (>= 1)
//
//   Ports
//     clk   in  single clock, rising edge
//     rst   in  synchronous, active-high reset
//     bus   slave modport of mux4_rr_arbiter_if:
//             req/data_in in; grant/sel/busy registered out;
//             data_out/valid_out combinational out
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux4_rr_arbiter_if.slave    bus
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        r_state;
    logic [3:0]    r_grant;
    logic [1:0]    r_sel;
    logic          r_busy;
    logic [HW-1:0] r_hold_cnt;
    logic [1:0]    r_last_ptr;

    logic [1:0]    w_pick_ptr;
    logic [2:0]    w_pick;
    logic          w_found;
    logic [1:0]    w_winner;
    logic          w_release;
    logic          w_valid;
    logic [DW-1:0] w_lane;

    // Returns {found, index}: first requester after ptr in wrap-around order,
    // ptr itself being the last candidate examined.
    function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // In GRANT the search only matters on release, and then the pointer has
    // just become the current owner, so r_sel is the pointer to search from.
    assign w_pick_ptr = (r_state == S_GRANT) ? r_sel : r_last_ptr;
    assign w_pick     = f_pick(bus.req, w_pick_ptr);
    assign w_found    = w_pick[2];
    assign w_winner   = w_pick[1:0];
    assign w_release  = !bus.req[r_sel] || (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'b0000;
            r_sel      <= 2'd0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
            r_last_ptr <= 2'd3;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        r_grant    <= 4'b0001 << w_winner;
                        r_sel      <= w_winner;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (!w_release) begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end else begin
                        r_last_ptr <= r_sel;
                        r_hold_cnt <= '0;
                        if (w_found) begin
                            // Zero-bubble handoff (may re-grant the same owner
                            // when nobody else is waiting).
                            r_grant <= 4'b0001 << w_winner;
                            r_sel   <= w_winner;
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output follows the owner's request combinationally so a dropped request
    // stops data in the same cycle, before the grant itself is released.
    assign w_valid = (|r_grant) & bus.req[r_sel];

    always_comb begin
        w_lane = '0;
        case (r_sel)
            2'd0:    w_lane = bus.data_in[0*DW +: DW];
            2'd1:    w_lane = bus.data_in[1*DW +: DW];
            2'd2:    w_lane = bus.data_in[2*DW +: DW];
            default: w_lane = bus.data_in[3*DW +: DW];
        endcase
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.busy      = r_busy;
    assign bus.valid_out = w_valid;
    assign bus.data_out  = w_valid ? w_lane : '0;

endmodule
